fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for a shared FIFO with bounded bursts, plus the authoritative occupancy count.
// fifo_wr_en/fifo_wr_data lag the accept by one cycle; while full the grant is held and producers stall.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          rd_req,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_rd_en,
    output logic [CNT_W-1:0]              occupancy,
    output logic                          full,
    output logic                          empty
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [BURST_W-1:0]     burst_q, burst_d;
    logic                   wr_en_q;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [CNT_W-1:0]       occ_q, occ_d;

    logic                   full_c, empty_c, rd_en_c;
    logic                   accept, owner_req, last_beat;
    logic [BURST_W-1:0]     burst_inc;
    logic [IDX_W:0]         pick;
    logic [NUM_REQ-1:0]     cand;
    logic [DATA_WIDTH-1:0]  wr_sel;

    // Returns {found, index} of the first candidate strictly after 'last', wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (c[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    always_comb begin
        full_c    = ({1'b0, occ_q} + {{CNT_W{1'b0}}, wr_en_q}) >= DEPTH_C;
        empty_c   = (occ_q == '0);
        rd_en_c   = rd_req & ~empty_c;
        owner_req = req[owner_q];
        accept    = (|(req & gnt_q)) & ~full_c;
        burst_inc = burst_q + BURST_W'(1);
        last_beat = accept & (burst_inc == BURST_W'(MAX_BURST));
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        burst_d = burst_q;
        pick    = '0;
        cand    = req;
        case (state_q)
            IDLE: begin
                pick = rr_pick(req, owner_q);
                if (pick[IDX_W]) begin
                    state_d = BURST;
                    gnt_d   = onehot(pick[IDX_W-1:0]);
                    owner_d = pick[IDX_W-1:0];
                    burst_d = '0;
                end
            end
            BURST: begin
                if (accept) burst_d = burst_inc;
                if (!owner_req || last_beat) begin
                    // Owner is always excluded here; it only keeps the grant if nobody else wants it.
                    cand = req & ~onehot(owner_q);
                    pick = rr_pick(cand, owner_q);
                    burst_d = '0;
                    if (pick[IDX_W]) begin
                        gnt_d   = onehot(pick[IDX_W-1:0]);
                        owner_d = pick[IDX_W-1:0];
                    end else if (!owner_req) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) wr_sel = wr_sel | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        wr_data_d = accept ? wr_sel : wr_data_q;
        case ({wr_en_q, rd_en_c})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= IDX_W'(NUM_REQ - 1);
            burst_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            wr_en_q   <= accept;
            wr_data_q <= wr_data_d;
            occ_q     <= occ_d;
        end
    end

    assign gnt          = gnt_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_rd_en   = rd_en_c;
    assign occupancy    = occ_q;
    assign full         = full_c;
    assign empty        = empty_c;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: randomized producers/consumer against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int MAXB  = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int VW    = N + 1 + DW + CW + 3;
    localparam logic [VW-1:0] RST_VEC = {N'(0), 1'b0, DW'(0), CW'(0), 1'b0, 1'b1, 1'b0};

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic              rd_req;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_rd_en;
    logic [CW-1:0]     occupancy;
    logic              full;
    logic              empty;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .rd_req(rd_req), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_rd_en(fifo_rd_en), .occupancy(occupancy), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner (-1 = nobody), previous owner, words this grant, FIFO count, in-flight word.
    int            m_owner, m_last, m_burst, m_occ, m_acc_p;
    bit            m_wr;
    logic [DW-1:0] m_wdata;
    int            words_left [N];
    logic [DW-1:0] acc_q [$];

    function automatic int rr_pick(logic [N-1:0] c, int last);
        for (int k = 1; k <= N; k++) begin
            if (c[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int acc, w;
        bit rdn, fl;
        logic [N-1:0] c;
        acc = -1;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_burst = 0; m_occ = 0;
            m_wr = 0; m_wdata = '0; m_acc_p = -1;
            return;
        end
        fl  = (m_occ + int'(m_wr)) >= DEPTH;
        rdn = rd_req && (m_occ > 0);
        if (m_owner >= 0 && req[m_owner] && !fl) acc = m_owner;
        m_occ = m_occ + int'(m_wr) - int'(rdn);
        m_wr  = (acc >= 0);
        if (acc >= 0) m_wdata = req_data[acc*DW +: DW];
        if (m_owner < 0) begin
            w = rr_pick(req, m_last);
            if (w >= 0) begin m_owner = w; m_last = w; m_burst = 0; end
        end else begin
            if (acc >= 0) m_burst++;
            if (!req[m_owner] || m_burst == MAXB) begin
                c = req;
                c[m_owner] = 1'b0;
                w = rr_pick(c, m_last);
                if (w >= 0) begin m_owner = w; m_last = w; m_burst = 0; end
                else if (req[m_owner]) m_burst = 0;
                else m_owner = -1;
            end
        end
        m_acc_p = acc;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {gnt, fifo_wr_en, fifo_wr_data, occupancy, full, empty, fifo_rd_en};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        bit fl, em;
        g  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        fl = (m_occ + int'(m_wr)) >= DEPTH;
        em = (m_occ == 0);
        return {g, m_wr, m_wdata, CW'(m_occ), fl, em, rd_req && !em};
    endfunction

    task automatic start_prod(input int p, input int n);
        words_left[p] = n;
        req[p] = 1'b1;
        req_data[p*DW +: DW] = DW'($urandom);
    endtask

    // Clock edge; producers then present their next word or drop req once out of words.
    task automatic advance();
        int p;
        model_step();
        @(posedge clk);
        #1;
        p = m_acc_p;
        if (p >= 0) begin
            acc_q.push_back(m_wdata);
            words_left[p]--;
            if (words_left[p] > 0) req_data[p*DW +: DW] = DW'($urandom);
            else req[p] = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        rd_req = 1'b0;
        req = '0;
        for (int p = 0; p < N; p++) words_left[p] = 0;
        repeat (n) advance();
        rst = 1'b0;
        acc_q.delete();
    endtask

    task automatic test_reset();
        do_reset(2);
        rd_req = 1'b1;
        #1;
        if (obs_vec() !== RST_VEC) begin
            $display("FAIL reset_state dut=%h exp=%h", obs_vec(), RST_VEC); miscompares++;
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL reset_model dut=%h exp=%h", obs_vec(), exp_vec()); miscompares++;
        end
        vectors++;
        rd_req = 1'b0;
    endtask

    task automatic test_single_burst();
        int pulses;
        pulses = 0;
        do_reset(2);
        start_prod(0, 6);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL burst_cycle%0d dut=%h exp=%h", c, obs_vec(), exp_vec()); miscompares++;
            end
            vectors++;
            if (gnt !== 4'b0000 && gnt !== 4'b0001) begin
                $display("FAIL burst_gnt dut=%b exp=0001", gnt); miscompares++;
            end
            vectors++;
            if (fifo_wr_en === 1'b1) begin
                pulses++;
                if (acc_q.size() == 0 || fifo_wr_data !== acc_q[0]) begin
                    $display("FAIL burst_data dut=%h exp=%h", fifo_wr_data,
                             (acc_q.size() == 0) ? 16'h0 : acc_q[0]);
                    miscompares++;
                end
                vectors++;
                if (acc_q.size() != 0) void'(acc_q.pop_front());
            end
            advance();
        end
        if (pulses != 6 || occupancy !== CW'(6)) begin
            $display("FAIL burst_total pulses=%0d occ=%0d exp pulses=6 occ=6", pulses, occupancy);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_rotation();
        int own [$];
        int cyc [$];
        do_reset(2);
        for (int p = 0; p < N; p++) start_prod(p, 8);
        rd_req = 1'b1;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL rot_cycle%0d dut=%h exp=%h", c, obs_vec(), exp_vec()); miscompares++;
            end
            vectors++;
            if ($countones(gnt) > 1) begin
                $display("FAIL rot_onehot dut=%b exp=onehot", gnt); miscompares++;
            end
            vectors++;
            if ((|(gnt & req)) && !full) begin
                for (int i = 0; i < N; i++) if (gnt[i]) own.push_back(i);
                cyc.push_back(c);
            end
            advance();
        end
        for (int k = 0; k < 20; k++) begin
            if (k >= own.size() || own[k] != (k / MAXB) % N || cyc[k] != cyc[0] + k) begin
                $display("FAIL rot_order accept%0d owner=%0d exp=%0d", k,
                         (k < own.size()) ? own[k] : -1, (k / MAXB) % N);
                miscompares++;
            end
            vectors++;
        end
        rd_req = 1'b0;
    endtask

    task automatic test_full();
        int pulses;
        pulses = 0;
        do_reset(2);
        start_prod(1, 20);
        for (int c = 0; c < 30; c++) begin
            #1;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL full_cycle%0d dut=%h exp=%h", c, obs_vec(), exp_vec()); miscompares++;
            end
            vectors++;
            if (fifo_wr_en === 1'b1) pulses++;
            advance();
        end
        if (pulses != DEPTH || occupancy !== CW'(DEPTH) || full !== 1'b1) begin
            $display("FAIL full_total pulses=%0d occ=%0d full=%b exp 16/16/1", pulses, occupancy, full);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_drain_one();
        for (int i = 0; i < 4; i++) begin
            rd_req = (i == 0);
            #1;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL drain_cycle%0d dut=%h exp=%h", i, obs_vec(), exp_vec()); miscompares++;
            end
            vectors++;
            if (i == 0 && (fifo_rd_en !== 1'b1 || occupancy !== CW'(16))) begin
                $display("FAIL drain_read rd_en=%b occ=%0d exp 1/16", fifo_rd_en, occupancy); miscompares++;
            end
            if (i == 1 && (occupancy !== CW'(15) || full !== 1'b0)) begin
                $display("FAIL drain_free occ=%0d full=%b exp 15/0", occupancy, full); miscompares++;
            end
            if (i == 3 && (occupancy !== CW'(16) || full !== 1'b1)) begin
                $display("FAIL drain_refill occ=%0d full=%b exp 16/1", occupancy, full); miscompares++;
            end
            if (i != 2) vectors++;
            advance();
        end
        rd_req = 1'b0;
    endtask

    task automatic test_empty_read();
        int rd_pulses, max_occ;
        rd_pulses = 0;
        max_occ = 0;
        do_reset(2);
        start_prod(2, 1);
        rd_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL empty_cycle%0d dut=%h exp=%h", c, obs_vec(), exp_vec()); miscompares++;
            end
            vectors++;
            if (fifo_rd_en === 1'b1) rd_pulses++;
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
            advance();
        end
        #1;
        if (rd_pulses != 1 || max_occ != 1 || occupancy !== CW'(0)) begin
            $display("FAIL empty_read rd=%0d max=%0d occ=%0d exp 1/1/0", rd_pulses, max_occ, occupancy);
            miscompares++;
        end
        vectors++;
        rd_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        start_prod(0, 10);
        start_prod(1, 10);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL rmid_cycle%0d dut=%h exp=%h", c, obs_vec(), exp_vec()); miscompares++;
            end
            vectors++;
            if (c < 2) advance();
        end
        if (fifo_wr_en !== 1'b1) begin
            $display("FAIL rmid_inflight wr_en=%b exp=1", fifo_wr_en); miscompares++;
        end
        vectors++;
        rst = 1'b1;
        advance();
        rst = 1'b0;
        #1;
        if (gnt !== '0 || fifo_wr_en !== 1'b0 || occupancy !== '0 || empty !== 1'b1) begin
            $display("FAIL rmid_after gnt=%b wr=%b occ=%0d empty=%b exp 0000/0/0/1",
                     gnt, fifo_wr_en, occupancy, empty);
            miscompares++;
        end
        vectors++;
        req[0] = 1'b0;
        words_left[0] = 0;
        start_prod(3, 2);
        advance();
        #1;
        if (gnt !== 4'b0010) begin
            $display("FAIL rmid_first_gnt dut=%b exp=0010", gnt); miscompares++;
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL rmid_model dut=%h exp=%h", obs_vec(), exp_vec()); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_random();
        do_reset(2);
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < N; p++) begin
                if (words_left[p] == 0 && $urandom_range(3) == 0) start_prod(p, 1 + $urandom_range(5));
                else if (words_left[p] > 0 && $urandom_range(31) == 0) begin
                    words_left[p] = 0;
                    req[p] = 1'b0;
                end
            end
            rd_req = ($urandom_range(4) < 2);
            rst = ($urandom_range(199) == 0);
            #1;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL rand_cycle%0d dut=%h exp=%h", c, obs_vec(), exp_vec()); miscompares++;
            end
            vectors++;
            if ($countones(gnt) > 1) begin
                $display("FAIL rand_onehot dut=%b exp=onehot", gnt); miscompares++;
            end
            vectors++;
            advance();
        end
        rst = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_data = '0;
        rd_req = 1'b0;
        for (int p = 0; p < N; p++) words_left[p] = 0;
        m_owner = -1; m_last = N - 1; m_burst = 0; m_occ = 0;
        m_wr = 0; m_wdata = '0; m_acc_p = -1;
        @(posedge clk);
        #1;
        test_reset();
        test_single_burst();
        test_rotation();
        test_full();
        test_drain_one();
        test_empty_read();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
